// File: rtl/osc_meas_sched_if.sv
// rtl/osc_meas_sched_if.sv - byte stream from the measurement sequencer to the UART transmitter
interface osc_meas_sched_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/osc_meas_sched.sv
// rtl/osc_meas_sched.sv - ring-oscillator measurement sequencer: settle, count window, capture, hysteresis flag, 3-byte record
module osc_meas_sched #(
  parameter int SETTLE_CYC = 16,
  parameter int WINDOW_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic             auto_run,
  input  logic [1:0]       osc_mode,
  input  logic [15:0]      thr_lo,
  input  logic [15:0]      thr_hi,
  input  logic [15:0]      cnt_val,
  output logic             en_inv_osc,
  output logic             en_nand_osc,
  output logic             cnt_clr,
  output logic             cnt_en,
  output logic             temp_warn,
  output logic             meas_done,
  output logic             busy,
  osc_meas_sched_if.master tx
);
  localparam int MAX_CYC = (SETTLE_CYC > WINDOW_CYC) ? SETTLE_CYC : WINDOW_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] WINDOW_LOAD = CW'(WINDOW_CYC - 1);

  typedef enum logic [2:0] {IDLE, SETTLE, WINDOW, CAPTURE, SEND} state_t;

  state_t        state_q;
  logic [CW-1:0] cyc_q;
  logic [1:0]    byte_q;
  logic [15:0]   meas_q;
  logic          osc_q;       // oscillator of the measurement in flight (0 inverter, 1 NAND)
  logic          next_osc_q;  // alternate-mode pick for the next launch, survives IDLE
  logic          inv_q, nand_q, clr_q, en_q, warn_q, done_q, busy_q, txv_q;
  logic [7:0]    txd_q;
  logic          sel_osc_d;
  logic          warn_d;

  // Oscillator choice for a launch and the hysteresis decision on the live counter value
  always_comb begin
    sel_osc_d = osc_mode[1] ? next_osc_q : osc_mode[0];
    warn_d    = warn_q;
    if (cnt_val <= thr_lo) begin
      warn_d = 1'b1;
    end else if (cnt_val >= thr_hi) begin
      warn_d = 1'b0;
    end
  end

  // Sequencer FSM; every output is a register updated on the transition into its state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cyc_q      <= '0;
      byte_q     <= 2'd0;
      meas_q     <= 16'd0;
      osc_q      <= 1'b0;
      next_osc_q <= 1'b0;
      inv_q      <= 1'b0;
      nand_q     <= 1'b0;
      clr_q      <= 1'b0;
      en_q       <= 1'b0;
      warn_q     <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      txv_q      <= 1'b0;
      txd_q      <= 8'd0;
    end else if (!ena) begin
      // Abort: everything but the warn flag, the stored result and next_osc returns to idle values
      state_q <= IDLE;
      cyc_q   <= '0;
      byte_q  <= 2'd0;
      inv_q   <= 1'b0;
      nand_q  <= 1'b0;
      clr_q   <= 1'b0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      txv_q   <= 1'b0;
      txd_q   <= 8'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start || auto_run) begin
            state_q <= SETTLE;
            osc_q   <= sel_osc_d;
            inv_q   <= ~sel_osc_d;
            nand_q  <= sel_osc_d;
            clr_q   <= 1'b1;
            busy_q  <= 1'b1;
            cyc_q   <= SETTLE_LOAD;
          end
        end
        SETTLE: begin
          if (cyc_q == '0) begin
            state_q <= WINDOW;
            clr_q   <= 1'b0;
            en_q    <= 1'b1;
            cyc_q   <= WINDOW_LOAD;
          end else begin
            cyc_q <= cyc_q - 1'b1;
          end
        end
        WINDOW: begin
          if (cyc_q == '0) begin
            // Counting stops here; the result and flag are taken on the same edge
            state_q <= CAPTURE;
            en_q    <= 1'b0;
            inv_q   <= 1'b0;
            nand_q  <= 1'b0;
            meas_q  <= cnt_val;
            warn_q  <= warn_d;
            done_q  <= 1'b1;
            if (osc_mode[1]) begin
              next_osc_q <= ~next_osc_q;
            end
          end else begin
            cyc_q <= cyc_q - 1'b1;
          end
        end
        CAPTURE: begin
          state_q <= SEND;
          byte_q  <= 2'd0;
          txv_q   <= 1'b1;
          txd_q   <= {7'b1010000, osc_q};
        end
        SEND: begin
          if (txv_q && tx.tx_ready) begin
            if (byte_q == 2'd2) begin
              txv_q <= 1'b0;
              txd_q <= 8'd0;
              if (auto_run) begin
                state_q <= SETTLE;
                osc_q   <= sel_osc_d;
                inv_q   <= ~sel_osc_d;
                nand_q  <= sel_osc_d;
                clr_q   <= 1'b1;
                cyc_q   <= SETTLE_LOAD;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              byte_q <= byte_q + 2'd1;
              txd_q  <= (byte_q == 2'd0) ? meas_q[15:8] : meas_q[7:0];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign en_inv_osc  = inv_q;
  assign en_nand_osc = nand_q;
  assign cnt_clr     = clr_q;
  assign cnt_en      = en_q;
  assign temp_warn   = warn_q;
  assign meas_done   = done_q;
  assign busy        = busy_q;
  assign tx.tx_valid = txv_q;
  assign tx.tx_data  = txd_q;
endmodule
